// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, two write-back ports, per-register
// busy scoreboard with stall outputs. Define REGFILE_BYPASS_EN for write-through forwarding.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              stallA,
  output logic              stallB,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valM,
  input  logic [DATA_W-1:0] valE,
  input  logic              we_,
  input  logic              issue_v,
  input  logic [ADDR_W-1:0] issue_dst
);

  localparam int NREG = 1 << ADDR_W;

  // Entry 0 is never written, so it stays at its reset value of zero.
  logic [DATA_W-1:0] rf [NREG];
  logic [NREG-1:0]   busy;

  logic wr_m;
  logic wr_e;

  assign wr_m = !we_ && (dstM != '0);
  assign wr_e = !we_ && (dstE != '0) && (dstE != dstM);

  // NOTE: the register array is reset because the reset state must read back as zero.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every write-back sees pre-edge state.
      if (wr_m) rf[dstM] <= valM;
      if (wr_e) rf[dstE] <= valE;
    end
  end

  // A new issue outranks a same-cycle retire: the newer producer is still outstanding.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      busy <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (issue_v && (issue_dst == ADDR_W'(r)))
          busy[r] <= 1'b1;
        else if (!we_ && ((dstM == ADDR_W'(r)) || (dstE == ADDR_W'(r))))
          busy[r] <= 1'b0;
      end
    end
  end

  logic [ADDR_W-1:0] src     [2];
  logic [DATA_W-1:0] rd_val  [2];
  logic              rd_stall[2];

  assign src[0] = srcA;
  assign src[1] = srcB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      // NOTE: defaults first so no path through this block infers a latch.
      rd_val[p]   = rf[src[p]];
      rd_stall[p] = busy[src[p]];
      if (src[p] == '0) begin
        rd_val[p]   = '0;
        rd_stall[p] = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (reset_ && !we_) begin
        if (src[p] == dstM) begin
          rd_val[p]   = valM;
          rd_stall[p] = 1'b0;
        end else if (src[p] == dstE) begin
          rd_val[p]   = valE;
          rd_stall[p] = 1'b0;
        end
      end
`endif
    end
  end

  assign valA   = rd_val[0];
  assign valB   = rd_val[1];
  assign stallA = rd_stall[0];
  assign stallB = rd_stall[1];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expected read results are queued as stimulus is driven
// and compared once the combinational outputs have settled.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_;
  logic [AW-1:0] srcA, srcB, dstM, dstE, issue_dst;
  logic [DW-1:0] valA, valB, valM, valE;
  logic          stallA, stallB, we_, issue_v;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_(reset_),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .stallA(stallA), .stallB(stallB),
    .dstM(dstM), .dstE(dstE), .valM(valM), .valE(valE),
    .we_(we_), .issue_v(issue_v), .issue_dst(issue_dst)
  );

  typedef struct {
    string         tag;
    logic [DW-1:0] a, b;
    logic          sa, sb;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] m_rf  [NR];
  logic          m_busy[NR];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_val(input logic [AW-1:0] s);
    if (s == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (reset_ && !we_ && s == dstM) return valM;
    if (reset_ && !we_ && s == dstE) return valE;
`endif
    return m_rf[s];
  endfunction

  function automatic logic m_stall(input logic [AW-1:0] s);
    if (s == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (reset_ && !we_ && (s == dstM || s == dstE)) return 1'b0;
`endif
    return m_busy[s];
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NR; r++) begin
      m_rf[r]   = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Model of one rising edge, using the inputs still being driven.
  task automatic m_edge();
    logic [DW-1:0] nrf[NR];
    logic          nb [NR];
    if (!reset_) return;
    nrf = m_rf;
    nb  = m_busy;
    if (!we_) begin
      if (dstM != 0) nrf[dstM] = valM;
      if (dstE != 0 && dstE != dstM) nrf[dstE] = valE;
      for (int r = 1; r < NR; r++)
        if (dstM == r || dstE == r) nb[r] = 1'b0;
    end
    if (issue_v && issue_dst != 0) nb[issue_dst] = 1'b1;
    m_rf   = nrf;
    m_busy = nb;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.a   = m_val(srcA);
    e.b   = m_val(srcB);
    e.sa  = m_stall(srcA);
    e.sb  = m_stall(srcB);
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, "_valA"},   valA,   e.a);
    check({e.tag, "_valB"},   valB,   e.b);
    check({e.tag, "_stallA"}, {31'd0, stallA}, {31'd0, e.sa});
    check({e.tag, "_stallB"}, {31'd0, stallB}, {31'd0, e.sb});
  endtask

  // Called at a falling edge: drive, check settled outputs, take the rising edge.
  task automatic step(input logic w, input logic [AW-1:0] dm, input logic [DW-1:0] vm,
                      input logic [AW-1:0] de, input logic [DW-1:0] ve,
                      input logic iv, input logic [AW-1:0] id,
                      input logic [AW-1:0] sa, input logic [AW-1:0] sb, input string tag);
    we_ = w; dstM = dm; valM = vm; dstE = de; valE = ve;
    issue_v = iv; issue_dst = id; srcA = sa; srcB = sb;
    push_exp(tag);
    #2;
    pop_check();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic rd(input logic [AW-1:0] sa, input logic [AW-1:0] sb, input string tag);
    step(1'b1, '0, '0, '0, '0, 1'b0, '0, sa, sb, tag);
  endtask

  initial begin
    reset_ = 1'b0;
    we_ = 1'b1; dstM = '0; dstE = '0; valM = '0; valE = '0;
    issue_v = 1'b0; issue_dst = '0; srcA = '0; srcB = '0;
    m_reset();
    @(negedge clk);
    rd(3'd3, 3'd5, "reset_hold");
    reset_ = 1'b1;
    rd(3'd1, 3'd7, "after_reset");

    // Write r3, mark it busy, then reset mid-cycle with a write pending.
    step(1'b0, 3'd3, 32'hDEADBEEF, 3'd0, '0, 1'b0, '0, 3'd0, 3'd0, "wr_r3");
    step(1'b1, '0, '0, '0, '0, 1'b1, 3'd3, 3'd3, 3'd0, "issue_r3");
    rd(3'd3, 3'd0, "r3_busy");
    we_ = 1'b0; dstM = 3'd3; valM = 32'h55; srcA = 3'd3; srcB = 3'd3;
    #2;
    reset_ = 1'b0;
    m_reset();
    #1;
    push_exp("mid_reset");
    pop_check();
    @(posedge clk);
    #2;
    push_exp("reset_edge");
    pop_check();
    @(negedge clk);
    reset_ = 1'b1;
    rd(3'd3, 3'd3, "write_discarded");

    // Dual write and collision.
    step(1'b0, 3'd2, 32'h11, 3'd5, 32'h22, 1'b0, '0, 3'd2, 3'd5, "dual_wr");
    rd(3'd2, 3'd5, "dual_rd");
    rd(3'd0, 3'd2, "zero_rd");
    step(1'b0, 3'd4, 32'hAA, 3'd4, 32'hBB, 1'b0, '0, 3'd4, 3'd0, "collide_wr");
    rd(3'd4, 3'd4, "collide_rd");

    // Scoreboard set, release on write-back, set-vs-clear.
    step(1'b1, '0, '0, '0, '0, 1'b1, 3'd6, 3'd6, 3'd0, "issue_r6");
    rd(3'd6, 3'd6, "r6_busy");
    step(1'b0, 3'd0, '0, 3'd6, 32'h33, 1'b0, '0, 3'd6, 3'd6, "r6_wb");
    rd(3'd6, 3'd0, "r6_free");
    step(1'b0, 3'd6, 32'h44, 3'd0, '0, 1'b1, 3'd6, 3'd6, 3'd0, "set_clear");
    rd(3'd6, 3'd6, "set_wins");
    step(1'b1, '0, '0, '0, '0, 1'b1, 3'd0, 3'd6, 3'd0, "issue_zero");

    // we_ high suppresses write and retire.
    step(1'b1, '0, '0, '0, '0, 1'b1, 3'd1, 3'd1, 3'd0, "issue_r1");
    step(1'b1, 3'd1, 32'h77, 3'd0, '0, 1'b0, '0, 3'd1, 3'd0, "we_high");
    rd(3'd1, 3'd1, "r1_kept");

    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), AW'($urandom), $urandom, AW'($urandom), $urandom,
           1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), AW'($urandom), "rand");

    if (sb_q.size() != 0) check("scoreboard_left", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
